// File: rtl/regfile_matrix_io.sv
// regfile_matrix_io: host-side initiator for a 32x32 register file.
// Streams LOAD_COUNT operand words into regs LOAD_BASE.., pulses start to the
// matrix core, waits for done, then reads RESULT_COUNT result regs starting at
// RESULT_BASE and emits them on a valid/ready stream.
//
// Optional feature: define REGFILE_IO_CLEAR_EN to add a CLEAR state that
// zeroes the result registers after the last result handshake.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_data/in_valid/in_ready operand stream (accepted on in_valid && in_ready)
//   start, done              core handshake (start pulse out, done in)
//   busy                     high whenever not IDLE
//   reg_write/write_reg/write_data  register-file write port
//   read_reg/read_data       register-file read port (combinational read)
//   out_data/out_valid/out_ready/out_last  result stream
module regfile_matrix_io #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned LOAD_BASE    = 1,
  parameter int unsigned LOAD_COUNT   = 8,
  parameter int unsigned RESULT_BASE  = 20,
  parameter int unsigned RESULT_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] read_reg,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned LCNT_W = $clog2(LOAD_COUNT + 1);
  localparam int unsigned RCNT_W = $clog2(RESULT_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3
`ifdef REGFILE_IO_CLEAR_EN
    ,CLEAR = 3'd4
`endif
  } state_t;

  state_t              state, state_d;
  logic [LCNT_W-1:0]   load_cnt, load_cnt_d;
  logic [RCNT_W-1:0]   res_cnt, res_cnt_d;
  logic                in_ready_d, start_d, busy_d;
  logic                reg_write_d;
  logic [ADDR_W-1:0]   write_reg_d, read_reg_d;
  logic [DATA_W-1:0]   write_data_d, out_data_d;
  logic                out_valid_d, out_last_d;
  logic                accept;

  assign accept = in_valid && in_ready;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_cnt   <= '0;
      res_cnt    <= '0;
      in_ready   <= 1'b1;
      start      <= 1'b0;
      busy       <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      read_reg   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state      <= state_d;
      load_cnt   <= load_cnt_d;
      res_cnt    <= res_cnt_d;
      in_ready   <= in_ready_d;
      start      <= start_d;
      busy       <= busy_d;
      reg_write  <= reg_write_d;
      write_reg  <= write_reg_d;
      write_data <= write_data_d;
      read_reg   <= read_reg_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    load_cnt_d   = load_cnt;
    res_cnt_d    = res_cnt;
    start_d      = 1'b0;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg;
    write_data_d = write_data;
    read_reg_d   = read_reg;
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    out_last_d   = out_last;

    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          reg_write_d  = 1'b1;
          write_reg_d  = ADDR_W'(LOAD_BASE) + ADDR_W'(load_cnt);
          write_data_d = in_data;
          load_cnt_d   = load_cnt + LCNT_W'(1);
          state_d      = LOAD;
        end else if (state == LOAD && load_cnt == LCNT_W'(LOAD_COUNT)) begin
          // last word was written this cycle; core may start next cycle
          state_d = RUN;
          start_d = 1'b1;
        end
      end

      RUN: begin
        if (done) begin
          state_d    = DRAIN;
          load_cnt_d = '0;
          res_cnt_d  = '0;
          read_reg_d = ADDR_W'(RESULT_BASE);
        end
      end

      DRAIN: begin
        if (!out_valid) begin
          // read_reg has been stable for a cycle: capture its data
          out_data_d  = read_data;
          out_valid_d = 1'b1;
          out_last_d  = (res_cnt == RCNT_W'(RESULT_COUNT - 1));
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (res_cnt == RCNT_W'(RESULT_COUNT - 1)) begin
            read_reg_d = '0;
`ifdef REGFILE_IO_CLEAR_EN
            // first clear write goes out with the final handshake
            state_d      = CLEAR;
            reg_write_d  = 1'b1;
            write_reg_d  = ADDR_W'(RESULT_BASE);
            write_data_d = '0;
            res_cnt_d    = RCNT_W'(1);
`else
            state_d   = IDLE;
            res_cnt_d = '0;
`endif
          end else begin
            res_cnt_d  = res_cnt + RCNT_W'(1);
            read_reg_d = read_reg + ADDR_W'(1);
          end
        end
      end

`ifdef REGFILE_IO_CLEAR_EN
      CLEAR: begin
        if (res_cnt == RCNT_W'(RESULT_COUNT)) begin
          state_d   = IDLE;
          res_cnt_d = '0;
        end else begin
          reg_write_d  = 1'b1;
          write_reg_d  = ADDR_W'(RESULT_BASE) + ADDR_W'(res_cnt);
          write_data_d = '0;
          res_cnt_d    = res_cnt + RCNT_W'(1);
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // in_ready drops the cycle after the final operand is accepted
    in_ready_d = (state_d == IDLE) ||
                 (state_d == LOAD && load_cnt_d != LCNT_W'(LOAD_COUNT));
    busy_d     = (state_d != IDLE);
  end

endmodule

// File: tb/tb_regfile_matrix_io.sv
// Testbench for regfile_matrix_io: register-file and matrix-core models,
// cycle-level behavioural checker, directed and random jobs.
module tb_regfile_matrix_io;

`ifdef REGFILE_IO_CLEAR_EN
  localparam int CLR_CYC = 4;
`else
  localparam int CLR_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic        done;
  logic        busy;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg;
  logic [31:0] read_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_matrix_io dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg  (read_reg),
    .read_data (read_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Register file plus a matrix core that computes C = A*B when started
  logic [31:0] rf [0:31];
  assign read_data = rf[read_reg];

  always @(posedge clk) begin
    if (reg_write) rf[write_reg] <= write_data;
    if (start) begin
      rf[20] <= rf[1] * rf[5] + rf[2] * rf[7];
      rf[21] <= rf[1] * rf[6] + rf[2] * rf[8];
      rf[22] <= rf[3] * rf[5] + rf[4] * rf[7];
      rf[23] <= rf[3] * rf[6] + rf[4] * rf[8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (cycle-indexed job timeline) ----------
  int          cyc = 0;
  bit          chk_en = 0;
  bit          active = 0;
  int          n_acc = 0;
  int          last_acc = -1;
  int          done_cyc = -1;
  int          next_valid = 0;
  int          words_out = 0;
  int          end_cyc = -1;
  int          clr_h = -1;
  logic [31:0] words [8];
  logic [31:0] cexp [4];
  bit          wr_pend = 0;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] got_q [$];

  task automatic job_clear();
    active = 0; n_acc = 0; last_acc = -1; done_cyc = -1;
    next_valid = 0; words_out = 0; end_cyc = -1; clr_h = -1;
  endtask

  always @(negedge clk) begin
    bit          e_ir, e_busy, e_start, e_ov, e_rw, e_rd;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;

    if (active && cyc == end_cyc) job_clear();

    e_ir    = !active || (n_acc < 8);
    e_busy  = active;
    e_start = active && last_acc >= 0 && cyc == last_acc + 2;
    e_ov    = active && done_cyc >= 0 && words_out < 4 && cyc >= next_valid;
    e_rd    = active && done_cyc >= 0 && cyc > done_cyc && words_out < 4;
    e_rw    = wr_pend;
    e_wreg  = wr_reg;
    e_wdata = wr_data;
    if (active && clr_h >= 0 && cyc > clr_h && cyc <= clr_h + CLR_CYC) begin
      e_rw    = 1'b1;
      e_wreg  = 5'(20 + cyc - clr_h - 1);
      e_wdata = '0;
    end

    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("start", 32'(start), 32'(e_start));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("reg_write", 32'(reg_write), 32'(e_rw));
      if (e_rw) begin
        chk("write_reg", 32'(write_reg), 32'(e_wreg));
        chk("write_data", write_data, e_wdata);
      end
      if (e_ov) begin
        chk("out_data", out_data, cexp[words_out]);
        chk("out_last", 32'(out_last), 32'(words_out == 3));
      end
      if (e_rd) chk("read_reg", 32'(read_reg), 32'(20 + words_out));
    end

    if (reset) begin
      job_clear();
      wr_pend = 0;
      chk_en  = 1;
    end else begin
      if (in_valid && e_ir) begin
        words[n_acc] = in_data;
        wr_pend = 1;
        wr_reg  = 5'(1 + n_acc);
        wr_data = in_data;
        active  = 1;
        n_acc++;
        if (n_acc == 8) begin
          last_acc = cyc;
          cexp[0] = words[0] * words[4] + words[1] * words[6];
          cexp[1] = words[0] * words[5] + words[1] * words[7];
          cexp[2] = words[2] * words[4] + words[3] * words[6];
          cexp[3] = words[2] * words[5] + words[3] * words[7];
        end
      end else begin
        wr_pend = 0;
      end
      if (last_acc >= 0 && cyc >= last_acc + 2 && done_cyc < 0 && done) begin
        done_cyc   = cyc;
        next_valid = cyc + 2;
      end
      if (e_ov && out_ready) begin
        got_q.push_back(out_data);
        words_out++;
        next_valid = cyc + 2;
        if (words_out == 4) begin
          end_cyc = cyc + 1 + CLR_CYC;
          clr_h   = cyc;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ------------------------------------------------
  // gap: 0 none, 1 toggle, 2 random; rdy: 0 always, 1 stall word 2, 2 random
  task automatic run_job(input int gap, input bit seq, input bit done_in_load,
                         input int done_delay, input int rdy);
    logic [31:0] w [8];
    int k, g, hs, stall;
    bit v, tog, acc;
    for (int i = 0; i < 8; i++) w[i] = seq ? 32'(i + 1) : $urandom;
    got_q.delete();
    k = 0; g = 0; tog = 1;
    done = done_in_load;
    while (k < 8 && g < 400) begin
      case (gap)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = w[k];
      acc = v && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      g++;
    end
    in_valid = 1'b0;
    done = 1'b0;
    chk("load_words_accepted", 32'(k), 32'd8);
    g = 0;
    while (!start && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("start_seen", 32'(start), 32'd1);
    repeat (done_delay) begin
      @(posedge clk); #1;
    end
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    hs = 0; g = 0; stall = 0;
    while (hs < 4 && g < 300) begin
      case (rdy)
        0:       out_ready = 1'b1;
        1:       out_ready = !(hs == 1 && out_valid && stall < 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (rdy == 1 && hs == 1 && out_valid && !out_ready) stall++;
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
      g++;
    end
    out_ready = 1'b0;
    chk("results_drained", 32'(hs), 32'd4);
    g = 0;
    while (busy && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle_after_job", 32'(busy), 32'd0);
  endtask

  // load three words, then reset mid-job
  task automatic reset_mid_job();
    int k, g;
    k = 0; g = 0;
    while (k < 3 && g < 50) begin
      in_valid = 1'b1;
      in_data  = 32'(100 + k);
      if (in_ready) k++;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_reg_write", 32'(reg_write), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; done = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_read_reg", 32'(read_reg), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // operands 1..8, no gaps; done 3 cycles after start
    run_job(0, 1'b1, 1'b0, 3, 0);
    chk("job1_nres", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("job1_c00", got_q[0], 32'd19);
      chk("job1_c01", got_q[1], 32'd22);
      chk("job1_c10", got_q[2], 32'd43);
      chk("job1_c11", got_q[3], 32'd50);
    end
    for (int i = 1; i <= 8; i++) chk("job1_rf", rf[i], 32'(i));
`ifdef REGFILE_IO_CLEAR_EN
    for (int i = 20; i <= 23; i++) chk("clear_rf", rf[i], 32'd0);
`endif

    // in_valid toggling 1-0-1
    run_job(1, 1'b1, 1'b0, 3, 0);
    // out_ready held low 5 cycles on the second result
    run_job(0, 1'b1, 1'b0, 1, 1);
    chk("stall_c01", (got_q.size() > 1) ? got_q[1] : 32'hFFFF_FFFF, 32'd22);

    // reset after 3 words, then a clean job starting at reg 1
    reset_mid_job();
    run_job(0, 1'b1, 1'b0, 3, 0);
    chk("post_reset_rf1", rf[1], 32'd1);

    // done asserted during IDLE/LOAD must be ignored
    done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_job(1, 1'b1, 1'b1, 2, 0);
    // done coinciding with start
    run_job(0, 1'b1, 1'b0, 0, 0);

    for (int j = 0; j < 12; j++)
      run_job(2, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 2);

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
